// File: rtl/gpio_pkg.sv
//------------------------------------------------------------------------------
// gpio_pkg : register-index helpers and reset constant for gpio_mm
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpio_pkg;

  localparam bit c_RST_BIT = 1'b0;

  function automatic int unsigned in_idx(input int unsigned i);
    return i;
  endfunction

  function automatic int unsigned out_idx(input int unsigned n_in, input int unsigned j);
    return n_in + j;
  endfunction

  function automatic int unsigned stat_idx(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out;
  endfunction

  function automatic int unsigned ie_idx(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync.sv
//------------------------------------------------------------------------------
// gpio_sync : three-stage input synchroniser with change detect on s2/s3
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpio_sync
  import gpio_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_s2,
  output logic         o_change
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= {W{c_RST_BIT}};
      r_s2 <= {W{c_RST_BIT}};
      r_s3 <= {W{c_RST_BIT}};
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_s2     = r_s2;
  assign o_change = |(r_s2 ^ r_s3);

endmodule

`default_nettype wire

// File: rtl/gpio_mm.sv
//------------------------------------------------------------------------------
// gpio_mm : memory-mapped GPIO with synchronised inputs, outputs, sticky IRQ
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpio_mm
  import gpio_pkg::*;
#(
  parameter int DW    = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       a,
  input  logic [DW-1:0]       wd,
  output logic [DW-1:0]       rd,
  input  logic [N_IN*DW-1:0]  gpi,
  output logic [N_OUT*DW-1:0] gpo,
  output logic                irq
);

  localparam logic [AW-1:0] c_STAT_A = AW'(stat_idx(N_IN, N_OUT));
  localparam logic [AW-1:0] c_IE_A   = AW'(ie_idx(N_IN, N_OUT));

  logic [DW-1:0]   w_in [N_IN];
  logic [N_IN-1:0] w_change;
  logic [N_IN-1:0] w_stat_clr;
  logic [DW-1:0]   r_out [N_OUT];
  logic [N_IN-1:0] r_stat;
  logic [N_IN-1:0] r_ie;

  for (genvar i = 0; i < N_IN; i++) begin : g_sync
    gpio_sync #(.W(DW)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .i_d      (gpi[i*DW +: DW]),
      .o_s2     (w_in[i]),
      .o_change (w_change[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_gpo
    assign gpo[j*DW +: DW] = r_out[j];
  end

  assign w_stat_clr = (we && a == c_STAT_A) ? wd[N_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < N_OUT; j++) r_out[j] <= {DW{c_RST_BIT}};
      r_stat <= {N_IN{c_RST_BIT}};
      r_ie   <= {N_IN{c_RST_BIT}};
    end else begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (we && a == AW'(out_idx(N_IN, j))) r_out[j] <= wd;
      end
      // A fresh detect overrides a same-cycle write-1-to-clear.
      r_stat <= (r_stat & ~w_stat_clr) | w_change;
      if (we && a == c_IE_A) r_ie <= wd[N_IN-1:0];
    end
  end

  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (a == AW'(in_idx(i))) rd = w_in[i];
    end
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if (a == AW'(out_idx(N_IN, j))) rd = r_out[j];
    end
    if (a == c_STAT_A) rd[N_IN-1:0] = r_stat;
    if (a == c_IE_A)   rd[N_IN-1:0] = r_ie;
  end

  assign irq = |(r_stat & r_ie);

endmodule

`default_nettype wire
